// File: rtl/stream_extremum_reduce_if.sv
// Valid/ready input stream and result stream of the multi-lane extremum reducer.
// STREAM_EXTREMUM_ARGMAX_EN adds the per-lane winning beat index (out_idx).
interface stream_extremum_reduce_if #(
    parameter int WIDTH  = 16,
    parameter int LANES  = 4,
    parameter int WINDOW = 4
);
    localparam int CW = $clog2(WINDOW + 1);
`ifdef STREAM_EXTREMUM_ARGMAX_EN
    localparam int IW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
`endif

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_last;
    logic                   min_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic [CW-1:0]          out_count;
`ifdef STREAM_EXTREMUM_ARGMAX_EN
    logic [LANES*IW-1:0]    out_idx;
`endif

`ifdef STREAM_EXTREMUM_ARGMAX_EN
    modport slave (
        input  in_valid, in_data, in_last, min_mode, out_ready,
        output in_ready, out_valid, out_data, out_count, out_idx
    );
    modport master (
        output in_valid, in_data, in_last, min_mode, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_idx
    );
`else
    modport slave (
        input  in_valid, in_data, in_last, min_mode, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
    modport master (
        output in_valid, in_data, in_last, min_mode, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
`endif
endinterface

// File: rtl/stream_extremum_reduce.sv
// Streaming multi-lane signed max/min reducer over windows of up to WINDOW beats.
// Define STREAM_EXTREMUM_ARGMAX_EN to also report the winning beat index per lane.
module stream_extremum_reduce #(
    parameter int WIDTH  = 16,
    parameter int LANES  = 4,
    parameter int WINDOW = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    stream_extremum_reduce_if.slave s
);
    localparam int CW = $clog2(WINDOW + 1);
`ifdef STREAM_EXTREMUM_ARGMAX_EN
    localparam int IW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
`endif

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   mode_q, mode_d;
    logic [LANES*WIDTH-1:0] acc_q, acc_d;
    logic                   out_valid_q, out_valid_d;
    logic [LANES*WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]          out_count_q, out_count_d;
`ifdef STREAM_EXTREMUM_ARGMAX_EN
    logic [LANES*IW-1:0]    acc_idx_q, acc_idx_d;
    logic [LANES*IW-1:0]    out_idx_q, out_idx_d;
    logic [LANES*IW-1:0]    red_idx;
`endif

    logic                   is_empty;
    logic                   eff_mode;
    logic [CW-1:0]          cnt_inc;
    logic                   complete_w;
    logic                   accept;
    logic                   drain;
    logic [LANES*WIDTH-1:0] red_flat;

    assign is_empty   = (state_q == ST_EMPTY);
    assign eff_mode   = is_empty ? s.min_mode : mode_q;
    assign cnt_inc    = cnt_q + CW'(1);
    assign complete_w = s.in_last || (WINDOW == 1) || (cnt_inc == CW'(WINDOW));

    // A held, undrained result only blocks a beat that would overwrite it.
    assign s.in_ready = ce & (~out_valid_q | s.out_ready | ~complete_w);
    assign accept     = s.in_valid & s.in_ready;
    assign drain      = ce & out_valid_q & s.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [WIDTH-1:0] acc_l;
            logic signed [WIDTH-1:0] in_l;
            logic                    take_in;

            assign acc_l = acc_q[gi*WIDTH +: WIDTH];
            assign in_l  = s.in_data[gi*WIDTH +: WIDTH];
            // Strict compare: on a tie the accumulator (earliest beat) is kept.
            assign take_in = is_empty | (eff_mode ? (in_l < acc_l) : (in_l > acc_l));
            assign red_flat[gi*WIDTH +: WIDTH] = take_in ? in_l : acc_l;
`ifdef STREAM_EXTREMUM_ARGMAX_EN
            assign red_idx[gi*IW +: IW] = take_in ? (is_empty ? IW'(0) : IW'(cnt_q))
                                                  : acc_idx_q[gi*IW +: IW];
`endif
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
`ifdef STREAM_EXTREMUM_ARGMAX_EN
        acc_idx_d   = acc_idx_q;
        out_idx_d   = out_idx_q;
`endif
        if (drain) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            acc_d = red_flat;
`ifdef STREAM_EXTREMUM_ARGMAX_EN
            acc_idx_d = red_idx;
`endif
            if (is_empty) begin
                mode_d = s.min_mode;
            end
            if (complete_w) begin
                state_d     = ST_EMPTY;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = red_flat;
                out_count_d = cnt_inc;
`ifdef STREAM_EXTREMUM_ARGMAX_EN
                out_idx_d   = red_idx;
`endif
            end else begin
                state_d = ST_ACCUM;
                cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
`ifdef STREAM_EXTREMUM_ARGMAX_EN
            acc_idx_q   <= '0;
            out_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
`ifdef STREAM_EXTREMUM_ARGMAX_EN
            acc_idx_q   <= acc_idx_d;
            out_idx_q   <= out_idx_d;
`endif
        end
    end

    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_count = out_count_q;
`ifdef STREAM_EXTREMUM_ARGMAX_EN
    assign s.out_idx   = out_idx_q;
`endif
endmodule

// File: tb/tb_stream_extremum_reduce.sv
// Directed bench for stream_extremum_reduce: a window-level reference model checks
// every cycle, and hand-computed literals pin the model on the key scenarios.
module tb_stream_extremum_reduce;
    localparam int W   = 16;
    localparam int L   = 4;
    localparam int WIN = 4;
    localparam int CW  = $clog2(WIN + 1);
    localparam int IW  = (WIN > 1) ? $clog2(WIN) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;

    int checks   = 0;
    int failures = 0;

    stream_extremum_reduce_if #(.WIDTH(W), .LANES(L), .WINDOW(WIN)) s ();

    stream_extremum_reduce #(.WIDTH(W), .LANES(L), .WINDOW(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .s   (s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [W-1:0] lane(input logic [L*W-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    function automatic logic [L*W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [L*W-1:0] v;
        v[0*W +: W] = W'(a);
        v[1*W +: W] = W'(b);
        v[2*W +: W] = W'(c);
        v[3*W +: W] = W'(d);
        return v;
    endfunction

    // Window-level reference model: remembers the beats of the open window and
    // scans them when the window closes.
    logic signed [W-1:0] win_v [WIN][L];
    int                  m_n;
    logic                m_mode;
    logic                m_valid;
    logic signed [W-1:0] m_data [L];
    int                  m_count;
    int                  m_idx [L];
    logic signed [W-1:0] rx [$];

    initial begin : model
        logic m_ready;
        logic signed [W-1:0] best;
        int bi;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_n = 0; m_mode = 1'b0; m_valid = 1'b0; m_count = 0;
                for (int k = 0; k < L; k++) begin
                    m_data[k] = '0; m_idx[k] = 0;
                end
            end
            chk("out_valid", 64'(s.out_valid), 64'(m_valid));
            chk("out_count", 64'(s.out_count), 64'(m_count));
            for (int k = 0; k < L; k++) begin
                chk($sformatf("out_data[%0d]", k), 64'(lane(s.out_data, k)), 64'(m_data[k]));
`ifdef STREAM_EXTREMUM_ARGMAX_EN
                chk($sformatf("out_idx[%0d]", k), 64'(s.out_idx[k*IW +: IW]), 64'(m_idx[k]));
`endif
            end
            if (!rst) begin
                m_ready = ce && (!m_valid || s.out_ready || !(s.in_last || (m_n + 1 == WIN)));
                chk("in_ready", 64'(s.in_ready), 64'(m_ready));
                if (ce) begin
                    if (m_valid && s.out_ready) begin
                        rx.push_back(m_data[0]);
                        $display("result drained: lane0=%0d count=%0d", m_data[0], m_count);
                        m_valid = 1'b0;
                    end
                    if (s.in_valid && m_ready) begin
                        if (m_n == 0) m_mode = s.min_mode;
                        for (int k = 0; k < L; k++) win_v[m_n][k] = lane(s.in_data, k);
                        m_n++;
                        if (s.in_last || m_n == WIN) begin
                            for (int k = 0; k < L; k++) begin
                                best = win_v[0][k]; bi = 0;
                                for (int j = 1; j < m_n; j++) begin
                                    if (m_mode ? (win_v[j][k] < best) : (win_v[j][k] > best)) begin
                                        best = win_v[j][k]; bi = j;
                                    end
                                end
                                m_data[k] = best; m_idx[k] = bi;
                            end
                            m_count = m_n;
                            m_valid = 1'b1;
                            m_n = 0;
                        end
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the edge that took the beat.
    task automatic send(input logic [L*W-1:0] d, input logic last, input logic mode,
                        output int stalls);
        logic rdy;
        stalls = 0;
        s.in_valid = 1'b1; s.in_data = d; s.in_last = last; s.min_mode = mode;
        forever begin
            @(negedge clk);
            rdy = s.in_ready;
            @(posedge clk); #1;
            if (rdy) break;
            stalls++;
            if (stalls > 50) begin
                chk("send_timeout", 64'(stalls), 64'(0));
                break;
            end
        end
        s.in_valid = 1'b0; s.in_last = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic expect_res(input string name, input int k, input int exp_v, input int exp_cnt);
        chk({name, "_valid"}, 64'(s.out_valid), 64'(1));
        chk({name, "_data"}, 64'(lane(s.out_data, k)), 64'(W'(exp_v)));
        chk({name, "_count"}, 64'(s.out_count), 64'(exp_cnt));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int st, tot, base;
        s.in_valid = 1'b0; s.in_data = '0; s.in_last = 1'b0; s.min_mode = 1'b0;
        s.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", 64'(s.out_valid), 64'(0));
        chk("reset_out_data", 64'(s.out_data), 64'(0));
        chk("reset_out_count", 64'(s.out_count), 64'(0));
        chk("reset_in_ready", 64'(s.in_ready), 64'(1));

        // 1: max over 3,-7,12,5; lane2 is all ties
        send(pack4(3, -3, 7, 1), 0, 0, st);
        send(pack4(-7, 7, 7, 2), 0, 0, st);
        send(pack4(12, -12, 7, 3), 0, 0, st);
        send(pack4(5, -5, 7, 4), 0, 0, st);
        expect_res("t1", 0, 12, 4);
        chk("t1_lane2_tie", 64'(lane(s.out_data, 2)), 64'(W'(7)));
`ifdef STREAM_EXTREMUM_ARGMAX_EN
        chk("t1_idx0", 64'(s.out_idx[0*IW +: IW]), 64'(2));
        chk("t1_idx2_tie", 64'(s.out_idx[2*IW +: IW]), 64'(0));
`endif
        $display("t1 done");

        // 2: min with both extremes
        send(pack4(-32768, 32767, 5, -1), 0, 1, st);
        send(pack4(32767, -32768, 5, -1), 0, 0, st);
        send(pack4(-1, -1, 5, -1), 0, 0, st);
        send(pack4(0, 0, 5, -1), 0, 0, st);
        expect_res("t2", 0, -32768, 4);
        chk("t2_lane1", 64'(lane(s.out_data, 1)), 64'(W'(-32768)));
`ifdef STREAM_EXTREMUM_ARGMAX_EN
        chk("t2_idx0", 64'(s.out_idx[0*IW +: IW]), 64'(0));
        chk("t2_idx1", 64'(s.out_idx[1*IW +: IW]), 64'(1));
`endif
        $display("t2 done");

        // 3: early in_last, then a clean full window
        send(pack4(-5, 1, 2, 3), 0, 0, st);
        send(pack4(-2, 0, 2, 3), 1, 0, st);
        expect_res("t3a", 0, -2, 2);
        for (int i = 1; i <= 4; i++) send(pack4(i, -i, 0, 100), 0, 0, st);
        expect_res("t3b", 0, 4, 4);
        $display("t3 done");

        // 4: backpressure with one held result
        step();
        s.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(pack4(10 * i, i, -i, 0), 0, 0, st);
        expect_res("t4a", 0, 40, 4);
        base = rx.size();
        tot = 0;
        for (int i = 1; i <= 3; i++) begin
            send(pack4(i, 0, 0, 0), 0, 0, st);
            tot += st;
        end
        chk("t4_no_early_stall", 64'(tot), 64'(0));
        s.in_valid = 1'b1; s.in_data = pack4(4, 0, 0, 0); s.in_last = 1'b0; s.min_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stalled_ready", 64'(s.in_ready), 64'(0));
            chk("t4_held_data", 64'(lane(s.out_data, 0)), 64'(W'(40)));
            @(posedge clk); #1;
        end
        s.out_ready = 1'b1;
        step();
        s.in_valid = 1'b0;
        expect_res("t4b", 0, 4, 4);
        step();
        chk("t4_drained_valid", 64'(s.out_valid), 64'(0));
        chk("t4_rx_size", 64'(rx.size() - base), 64'(2));
        if (rx.size() >= base + 2) begin
            chk("t4_rx_first", 64'(rx[base]), 64'(W'(40)));
            chk("t4_rx_second", 64'(rx[base + 1]), 64'(W'(4)));
        end
        $display("t4 done");

        // 5: 16 back-to-back beats, no stalls
        base = rx.size();
        tot = 0;
        for (int i = 0; i < 16; i++) begin
            send(pack4($urandom, $urandom, $urandom, $urandom), 0, 1'($urandom_range(1)), st);
            tot += st;
        end
        step();
        chk("t5_stalls", 64'(tot), 64'(0));
        chk("t5_results", 64'(rx.size() - base), 64'(4));
        $display("t5 done");

        // ce freeze mid-window and on a held valid result
        send(pack4(5, 0, 0, 0), 0, 0, st);
        send(pack4(1, 0, 0, 0), 0, 0, st);
        ce = 1'b0;
        s.in_valid = 1'b1; s.in_data = pack4(9, 0, 0, 0);
        repeat (3) step();
        ce = 1'b1;
        send(pack4(9, 0, 0, 0), 0, 0, st);
        send(pack4(2, 0, 0, 0), 0, 0, st);
        ce = 1'b0;
        repeat (2) step();
        expect_res("ce_hold", 0, 9, 4);
        ce = 1'b1;
        step();
        $display("ce done");

        // 6: reset mid-window discards it; min_mode ignored after the first beat
        base = rx.size();
        send(pack4(9, 9, 9, 9), 0, 0, st);
        send(pack4(9, 9, 9, 9), 0, 0, st);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t6_no_result", 64'(s.out_valid), 64'(0));
            step();
        end
        for (int i = 1; i <= 4; i++) send(pack4(i, -i, i, 0), 0, (i != 1), st);
        expect_res("t6", 0, 4, 4);
        chk("t6_lane1", 64'(lane(s.out_data, 1)), 64'(W'(-1)));
        step();
        chk("t6_rx", 64'(rx.size() - base), 64'(1));
        $display("t6 done");

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
